dmem_line_ctrl: RTL
===================

DMEM_LINE_CTRL -- requirements
Module: dmem_line_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_WORDS_LOG2, default 15, giving the log2 of the backing-store depth in 32-bit words (128 KiB).
REQ-002 The block SHALL have parameter FIRST_LAT, default 4, giving the first-word access latency in cycles; the legal range is 1..15.
REQ-003 The block SHALL have port clk, input, 1 bit: the clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 The block SHALL have port req_valid, input, 1 bit: the cache presents a line request.
REQ-006 The block SHALL have port req_ready, output, 1 bit: the controller can accept a request this cycle.
REQ-007 The block SHALL have port req_we, input, 1 bit: 1 = line writeback, 0 = line refill.
REQ-008 The block SHALL have port req_addr, input, 32 bits: byte address of the line; bits [3:0] are ignored.
REQ-009 The block SHALL have port req_wline, input, 128 bits: the writeback line, with word0 in [31:0] and word3 in [127:96].
REQ-010 The block SHALL have port resp_valid, output, 1 bit: one-cycle completion pulse.
REQ-011 The block SHALL have port resp_rline, output, 128 bits: the refilled line, using the same word packing as req_wline.
REQ-012 The block SHALL have port busy, output, 1 bit: a transaction is in flight.

Function
REQ-013 The block SHALL implement the FSM states IDLE, WAIT, XFER and RESP.
REQ-014 req_ready SHALL be 1 only in IDLE, and busy SHALL equal (state != IDLE).
REQ-015 A request SHALL be accepted on a rising edge where req_valid && req_ready; on acceptance the block SHALL latch req_addr[31:4], req_we and req_wline, load lat_cnt = FIRST_LAT-1 and go IDLE->WAIT.
REQ-016 req_valid SHALL be ignored outside IDLE, and the latched values SHALL NOT change until the next acceptance.
REQ-017 In WAIT, lat_cnt SHALL decrement each cycle; when lat_cnt==0 the block SHALL go to XFER with beat_cnt=0, so WAIT lasts exactly FIRST_LAT cycles.
REQ-018 In XFER, one word SHALL be transferred per cycle for beat_cnt 0..3, and beat_cnt==3 SHALL go to RESP.
REQ-019 The word index of each beat SHALL be {line_addr, beat_cnt} truncated to ADDR_WORDS_LOG2 bits; address bits above the store size SHALL alias (wrap modulo the depth) with no error.
REQ-020 On a refill beat, the block SHALL read store[index] combinationally and register it into resp_rline[beat*32 +: 32] at the edge.
REQ-021 On a writeback beat, the block SHALL write the latched wline word to store[index] at the edge, and resp_rline SHALL be unchanged.
REQ-022 resp_valid SHALL be 1 for exactly the one RESP cycle, after which the block SHALL go RESP->IDLE.
REQ-023 Latency: for an acceptance edge at the end of cycle T, resp_valid SHALL be high in cycle T+FIRST_LAT+5 (cycle T+9 at the default).
REQ-024 A request held through RESP SHALL NOT be accepted until the following IDLE cycle, giving a minimum spacing between acceptance edges of FIRST_LAT+6 cycles.
REQ-025 resp_rline SHALL hold its value from RESP until the next refill overwrites individual words during XFER.
REQ-026 A request whose req_addr[3:0] is nonzero SHALL behave identically to the same request with those bits zero.
REQ-027 The store SHALL be single-ported; there is no read/write concurrency because only one beat is active per cycle.

Reset
REQ-028 While rst=1, the block SHALL hold state=IDLE, lat_cnt=0, beat_cnt=0, resp_valid=0, busy=0, req_ready=1 and resp_rline=0.
REQ-029 A reset asserted mid-transaction SHALL abort it, with no resp_valid pulse; writeback beats already committed SHALL remain in the store and later beats SHALL NOT be written.
REQ-030 The store array SHALL NOT be reset, and a bench SHALL preload it from a hex file.

Verification
REQ-031 Refill test: preload words 0x40..0x43 with 11111111, 22222222, 33333333, 44444444; issue a refill at req_addr=0x100 -> resp_valid=1 exactly 9 cycles after acceptance and resp_rline=44444444_33333333_22222222_11111111.
REQ-032 Writeback then refill test: writeback req_wline=DEADBEEF_CAFEF00D_01234567_89ABCDEF to 0x200, then refill 0x20C -> the refill returns the same 128 bits, and words 0x80..0x83 hold 89ABCDEF, 01234567, CAFEF00D, DEADBEEF.
REQ-033 Handshake test: hold req_valid=1 continuously -> req_ready=0 and busy=1 from WAIT through RESP, acceptances occur exactly every 10 cycles, and exactly one resp_valid pulse occurs per acceptance.
REQ-034 Alias test: with ADDR_WORDS_LOG2=15, refill 0x00020100 -> returns the same data as 0x00000100.
REQ-035 Reset-abort test: assert rst during XFER beat 2 of a writeback -> store words 0 and 1 are updated, words 2 and 3 keep their preload, no resp_valid pulse occurs, and the next request completes normally.
REQ-036 Parameter test: FIRST_LAT=1 -> resp_valid is high 6 cycles after acceptance.

Source files
------------

// File: rtl/dmem_line_ctrl.sv
// Line-granular controller in front of a single-ported 32-bit word store.
// It serves one 128-bit refill or writeback at a time: it waits a fixed
// first-word latency, moves four word beats, then pulses resp_valid.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | ready for a request; req_ready=1
// WAIT  | first-word latency countdown (lat_cnt), lasts FIRST_LAT cycles
// XFER  | one word per cycle, beat_cnt 0..3
// RESP  | one-cycle resp_valid pulse, then back to IDLE
module dmem_line_ctrl #(
    parameter int ADDR_WORDS_LOG2 = 15,
    parameter int FIRST_LAT       = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_we,
    input  logic [31:0]  req_addr,
    input  logic [127:0] req_wline,
    output logic         resp_valid,
    output logic [127:0] resp_rline,
    output logic         busy
);

    localparam int DEPTH = 1 << ADDR_WORDS_LOG2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        XFER = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [3:0]   lat_cnt;
    logic [1:0]   beat_cnt;
    logic [27:0]  line_addr;
    logic         we_q;
    logic [127:0] wline_q;

    logic [31:0]  store [DEPTH];

    logic [ADDR_WORDS_LOG2-1:0] word_idx;
    logic [31:0]  rd_word;
    logic [31:0]  wr_word;
    logic         accept;
    logic         store_we;

    // The low nibble of the byte address selects bytes inside the line and
    // has no effect on the transfer.
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr[3:0];

    // Line address bits beyond the store depth are dropped, so the store
    // aliases silently modulo its size.
    assign word_idx = ADDR_WORDS_LOG2'({line_addr, beat_cnt});
    assign rd_word  = store[word_idx];
    assign wr_word  = wline_q[{beat_cnt, 5'd0} +: 32];
    assign accept   = req_valid && (state == IDLE);
    // Reset forces state to IDLE immediately, which also blocks any beat
    // still pending at the next edge.
    assign store_we = (state == XFER) && we_q;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        busy       = 1'b1;
        resp_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (lat_cnt == 4'd0) begin
                    state_nxt = XFER;
                end
            end
            XFER: begin
                if (beat_cnt == 2'd3) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                state_nxt  = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Request latching, latency/beat counters and refill line assembly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_cnt    <= 4'd0;
            beat_cnt   <= 2'd0;
            line_addr  <= 28'd0;
            we_q       <= 1'b0;
            wline_q    <= 128'd0;
            resp_rline <= 128'd0;
        end else begin
            case (state)
                IDLE: begin
                    beat_cnt <= 2'd0;
                    if (accept) begin
                        line_addr <= req_addr[31:4];
                        we_q      <= req_we;
                        wline_q   <= req_wline;
                        lat_cnt   <= 4'(FIRST_LAT - 1);
                    end
                end
                WAIT: begin
                    beat_cnt <= 2'd0;
                    if (lat_cnt != 4'd0) begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end
                end
                XFER: begin
                    beat_cnt <= beat_cnt + 2'd1;
                    if (!we_q) begin
                        resp_rline[{beat_cnt, 5'd0} +: 32] <= rd_word;
                    end
                end
                default: begin
                    beat_cnt <= 2'd0;
                end
            endcase
        end
    end

    // Backing store write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (store_we) begin
            store[word_idx] <= wr_word;
        end
    end

endmodule
